// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin packet-locked arbiter sharing one serial tx stream between requesters
module rs232_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 32,
  parameter logic [7:0] EOP_CHAR = 8'h0A,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_REQ*WIDTH-1:0] input_req_data,
  input  logic [N_REQ-1:0] input_req_stb,
  output logic [N_REQ-1:0] input_req_ack,
  output logic [WIDTH-1:0] output_rs232_tx,
  output logic output_rs232_tx_stb,
  input  logic output_rs232_tx_ack,
  output logic [N_REQ-1:0] grant,
  output logic timeout_event
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACCEPT = 2'd1, SEND = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, win, idx;
  logic found;
  logic [CW-1:0] cnt;
  // ptr holds the current owner while granted, and the last winner once idle
  always_comb begin
    win = ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && input_req_stb[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign input_req_ack = state == ACCEPT ? grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= PW'(N_REQ - 1);
      cnt <= '0;
      output_rs232_tx <= '0;
      output_rs232_tx_stb <= 1'b0;
      timeout_event <= 1'b0;
    end else begin
      timeout_event <= 1'b0;
      case (state)
        IDLE: if (|input_req_stb) begin
          grant <= N_REQ'(1) << win;
          ptr <= win;
          cnt <= '0;
          state <= ACCEPT;
        end
        ACCEPT: if (input_req_stb[ptr]) begin
          output_rs232_tx <= input_req_data[ptr*WIDTH +: WIDTH];
          output_rs232_tx_stb <= 1'b1;
          state <= SEND;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          grant <= '0;
          timeout_event <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        SEND: if (output_rs232_tx_ack) begin
          output_rs232_tx_stb <= 1'b0;
          cnt <= '0;
          if (output_rs232_tx[7:0] == EOP_CHAR) begin
            grant <= '0;
            state <= IDLE;
          end else state <= ACCEPT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// tb_rs232_tx_arbiter: directed and randomized checks of rs232_tx_arbiter against a transaction-level model
module tb_rs232_tx_arbiter;
  localparam int N = 3;
  localparam int TMO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*32-1:0] data;
  logic [N-1:0] stb, ack, grant;
  logic [31:0] tx;
  logic tx_stb, tx_ack, tev;
  int n_chk = 0, n_err = 0;
  logic [31:0] txq [N][$];
  logic [31:0] pend[$], outq[$], expq[$];
  int gap [N];
  bit rnd = 1'b0;
  logic [N-1:0] took = '0;
  int mptr = N - 1, idle = 0, lock_r = 0;
  bit lock_v = 1'b0, arb_v = 1'b0, tmo_v = 1'b0, hold = 1'b0;
  logic [N-1:0] exp_g;
  logic exp_t;
  logic [31:0] hold_d;

  rs232_tx_arbiter #(.N_REQ(N), .WIDTH(32), .EOP_CHAR(8'h0A), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .input_req_data(data), .input_req_stb(stb), .input_req_ack(ack),
    .output_rs232_tx(tx), .output_rs232_tx_stb(tx_stb), .output_rs232_tx_ack(tx_ack),
    .grant(grant), .timeout_event(tev));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] s);
    for (int k = 1; k <= N; k++)
      if (s[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!(txq[0].size() == 0 && txq[1].size() == 0 && txq[2].size() == 0 &&
             stb == 0 && !tx_stb && grant == 0) && n < lim) begin
      tick;
      n++;
    end
    check("idle_reached", n < lim, 1);
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_count"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++) check(tag, outq[i], expq[i]);
  endtask

  task automatic push_packet(input int r);
    int len = $urandom_range(1, 4);
    logic [31:0] w;
    for (int i = 0; i < len; i++) begin
      w = $urandom();
      if (i == len - 1) w[7:0] = 8'h0A;
      else if (w[7:0] == 8'h0A) w[7:0] = 8'h0B;
      txq[r].push_back(w);
    end
  endtask

  // requester drivers: hold each word until it is taken, optional gaps between words
  initial begin
    stb = '0;
    data = '0;
    forever begin
      tick;
      for (int r = 0; r < N; r++) begin
        if (took[r]) begin
          void'(txq[r].pop_front());
          stb[r] = 1'b0;
          gap[r] = !rnd ? 0 : $urandom_range(0, 19) == 0 ? int'($urandom_range(10, 24)) : int'($urandom_range(0, 2));
        end
        if (!stb[r] && txq[r].size() > 0) begin
          if (gap[r] > 0) gap[r]--;
          else begin
            stb[r] = 1'b1;
            data[r*32 +: 32] = txq[r][0];
          end
        end
      end
    end
  end

  // reference model: predicts grant and timeout, scoreboards words and packet contiguity
  always @(negedge clk) begin
    if (arb_v) check("arb_grant", grant, exp_g);
    if (tmo_v) check("timeout_event", tev, exp_t);
    if (hold) begin
      check("hold_stb", tx_stb, 1);
      check("hold_data", tx, hold_d);
    end
    if (rst) begin
      pend.delete();
      lock_v = 1'b0;
      idle = 0;
      mptr = N - 1;
      took = '0;
      exp_g = '0;
      exp_t = 1'b0;
      arb_v = 1'b1;
      tmo_v = 1'b1;
      hold = 1'b0;
    end else begin
      check("ack_in_grant", ack & ~grant, 0);
      check("grant_onehot", $onehot0(grant), 1);
      took = stb & ack;
      arb_v = grant == 0;
      if (grant == 0) begin
        exp_g = '0;
        if (|stb) begin
          mptr = rr_pick(mptr, stb);
          exp_g = N'(1) << mptr;
        end
      end
      for (int r = 0; r < N; r++) if (took[r]) begin
        pend.push_back(data[r*32 +: 32]);
        if (lock_v) check("contiguous", r, lock_r);
        lock_r = r;
        lock_v = data[r*32 +: 8] != 8'h0A;
      end
      idle = (grant != 0 && !tx_stb && took == 0) ? idle + 1 : 0;
      exp_t = idle == TMO;
      if (exp_t) begin
        lock_v = 1'b0;
        idle = 0;
      end
      tmo_v = 1'b1;
      if (tx_stb && tx_ack) begin
        outq.push_back(tx);
        if (pend.size() == 0) check("out_spurious", 1, 0);
        else check("out_data", tx, pend.pop_front());
      end
      hold = tx_stb && !tx_ack;
      hold_d = tx;
    end
  end

  initial begin
    int n;
    tx_ack = 1'b0;
    repeat (3) tick;
    check("rst_tx", tx, 0);
    check("rst_stb", tx_stb, 0);
    check("rst_ack", ack, 0);
    check("rst_grant", grant, 0);
    check("rst_tev", tev, 0);
    // single requester line, transmitter always ready
    tx_ack = 1'b1;
    txq[0].push_back(32'h48);
    txq[0].push_back(32'h69);
    txq[0].push_back(32'h0A);
    rst = 1'b0;
    wait_idle(200);
    expq = {32'h48, 32'h69, 32'h0A};
    compare_out("t1_out");
    // two simultaneous lines from reset, then a second round
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      txq[0].push_back(32'h0000_00A1);
      txq[0].push_back(32'h0000_010A);
      txq[1].push_back(32'h0000_00B1);
      txq[1].push_back(32'h0000_020A);
      if (k == 0) begin
        tick;
        tick;
        outq.delete();
        rst = 1'b0;
      end
      wait_idle(300);
    end
    expq = {32'hA1, 32'h10A, 32'hB1, 32'h20A, 32'hA1, 32'h10A, 32'hB1, 32'h20A};
    compare_out("t2_out");
    // stalled requester loses its grant after the timeout
    outq.delete();
    txq[1].push_back(32'h41);
    n = 0;
    while (!(grant == 3'b010 && !tx_stb && outq.size() == 1) && n < 100) begin
      tick;
      n++;
    end
    txq[0].push_back(32'h0A);
    n = 0;
    while (!tev && n < 100) begin
      tick;
      n++;
    end
    check("t3_tmo_cycles", n, TMO);
    check("t3_tmo_grant", grant, 0);
    wait_idle(200);
    expq = {32'h41, 32'h0A};
    compare_out("t3_out");
    // transmitter back-pressure
    outq.delete();
    tx_ack = 1'b0;
    txq[0].push_back(32'h1234_5641);
    n = 0;
    while (!tx_stb && n < 50) begin
      tick;
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      check("t4_data", tx, 32'h1234_5641);
      check("t4_stb", tx_stb, 1);
      check("t4_ack", ack, 0);
      tick;
    end
    tx_ack = 1'b1;
    wait_idle(200);
    expq = {32'h1234_5641};
    compare_out("t4_out");
    // reset while a word waits in SEND
    outq.delete();
    tx_ack = 1'b0;
    txq[0].push_back(32'h55);
    n = 0;
    while (!tx_stb && n < 50) begin
      tick;
      n++;
    end
    check("t5_send", tx_stb, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5_stb", tx_stb, 0);
    check("t5_grant", grant, 0);
    tx_ack = 1'b1;
    repeat (10) tick;
    check("t5_out", outq.size(), 0);
    // randomized traffic
    outq.delete();
    rnd = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int r = 0; r < N; r++)
        if (txq[r].size() == 0 && $urandom_range(0, 3) == 0) push_packet(r);
      tx_ack = $urandom_range(0, 9) < 7;
      tick;
    end
    rnd = 1'b0;
    tx_ack = 1'b1;
    wait_idle(3000);
    check("t6_pending", pend.size(), 0);
    check("t6_activity", outq.size() > 200, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
